vga_plot_scanout: RTL and testbench
===================================

Name: vga_plot_scanout

Overview:
- Consumer end of the plot interface: accepts plot requests (iX, iY, iColour, iPlot) and writes them into a 320x240x3 framebuffer.
- Continuously scans the framebuffer out as a 640x480@60 VGA raster, with each stored pixel doubled horizontally and vertically.
- Sits between the keyboard/menu drawing datapaths and the board VGA DAC.
- Also provides a clear-screen sweep and a frame-start pulse.

Parameters:
- X_SCREEN_PIXELS, 320, framebuffer width.
- Y_SCREEN_PIXELS, 240, framebuffer height.
- BACKGROUND, 3'b000, colour written by a clear sweep.
- H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixel clocks.
- V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines.

Ports:
- iClock  in  1  system clock, 50 MHz.
- iResetn  in  1  asynchronous active-low reset.
- iX  in  9  plot x coordinate.
- iY  in  8  plot y coordinate.
- iColour  in  3  plot colour, {R,G,B}.
- iPlot  in  1  write enable; one pixel written per cycle it is high.
- iClear  in  1  start clear sweep (level, sampled each cycle).
- oBusy  out  1  clear sweep in progress.
- oVGA_R/oVGA_G/oVGA_B  out  8 each  colour bit replicated to all 8 bits.
- oVGA_HS  out  1  hsync, active low.
- oVGA_VS  out  1  vsync, active low.
- oVGA_BLANK_N  out  1  high in the visible region.
- oVGA_SYNC_N  out  1  constant 0.
- oVGA_CLK  out  1  pixel clock = pix_en phase, 25 MHz.
- oFrameStart  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (asynchronous): pix_en=0, h=0, v=0, clear FSM IDLE, clear address 0.
  - Outputs: oBusy=0, HS=1, VS=1, BLANK_N=0, RGB=0, oFrameStart=0.
  - Framebuffer RAM contents are not reset.
- pix_en toggles every iClock.
- h counts 0..799 and advances when pix_en=1; it wraps to 0 and increments v.
- v counts 0..524 and wraps to 0.
- Raw timing signals from the counters:
  - visible = h<640 && v<480.
  - HS low for h in 656..751.
  - VS low for v in 490..491.
- Read address = (v>>1)*320 + (h>>1), computed as ((v>>1)<<8)+((v>>1)<<6)+(h>>1), 17 bits.
- Read pipeline:
  - Stage 1 registers the address; the RAM gives a registered read.
  - HS/VS/visible are delayed by two matching register stages.
  - RGB, HS, VS and BLANK_N all change on the same edge, 2 iClock cycles after the counter values that produced them.
  - RGB=0 whenever BLANK_N=0.
- oFrameStart = 1 for exactly one iClock, in the cycle where h=0, v=0 and pix_en=1.
- Write port:
  - When iPlot=1, FSM is IDLE, iX<320 and iY<240: write iColour at iY*320+iX on that edge.
  - Out-of-range coordinates are silently dropped.
  - No backpressure; every in-range plot while IDLE is written in one cycle.
- Read-during-write to the same address returns old data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when iClear=1; clear address=0, oBusy=1 on the next cycle.
  - CLEAR: write BACKGROUND at the clear address each cycle, then increment it.
  - At address 76799, write it, then go to IDLE; oBusy=0 on the next cycle. Total 76800 write cycles.
  - iPlot during CLEAR is dropped, including the cycle iClear is first seen.
  - iClear during CLEAR is ignored; no restart.
- Scan-out never stalls during a clear or during writes.
- Reset asserted mid-clear aborts the sweep.
  - The RAM is left partially cleared.
  - The FSM returns to IDLE; oBusy=0.

Test Plan:
1. Reset, then run 2 frames.
   - HS low pulses are 192 iClock wide with an 1600-iClock period.
   - VS is low for 2 lines (3200 iClock), with a frame period of 840000 iClock.
   - BLANK_N is high for 1280 iClock per line on lines 0..479.
   - oFrameStart pulses once per frame.
2. Plot iX=0, iY=0, colour 110, and iX=319, iY=239, colour 001.
   - Screen (0..1, 0..1) shows R=G=FF, B=00.
   - Screen (638..639, 478..479) shows B=FF only.
   - All signals are aligned 2 cycles after the counters.
3. Plot iX=320, iY=10, colour 111, then iX=5, iY=240, colour 111.
   - No pixel changes anywhere; row 10 column 0 keeps its old value.
4. Set BACKGROUND=3'b011 and pulse iClear.
   - oBusy stays high for exactly 76800 cycles.
   - The next frame is entirely G=B=FF, R=00.
   - A plot issued during the sweep is absent.
5. iClear and iPlot (x=10, y=10) asserted on the same cycle.
   - Clear wins; pixel (10,10) ends as BACKGROUND.
6. Assert iResetn=0 30000 cycles into a clear.
   - oBusy drops immediately; RAM addresses below 30000 hold BACKGROUND.
   - Later addresses are unchanged.
   - Scan-out restarts at h=0, v=0.

Source files
------------

// File: rtl/vga_plot_scanout.sv
// Plot-port framebuffer (3-bit colour) with a clear sweep and a
// pixel-doubled VGA scan-out; all timing is derived from the parameters.
module vga_plot_scanout #(
  parameter int         X_SCREEN_PIXELS = 320,
  parameter int         Y_SCREEN_PIXELS = 240,
  parameter logic [2:0] BACKGROUND      = 3'b000,
  parameter int         H_VISIBLE       = 640,
  parameter int         H_FRONT         = 16,
  parameter int         H_SYNC          = 96,
  parameter int         H_BACK          = 48,
  parameter int         V_VISIBLE       = 480,
  parameter int         V_FRONT         = 10,
  parameter int         V_SYNC          = 2,
  parameter int         V_BACK          = 33
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic [8:0] iX,
  input  logic [7:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  input  logic       iClear,
  output logic       oBusy,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N,
  output logic       oVGA_CLK,
  output logic       oFrameStart
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int NPIX    = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int AW      = 17;
  localparam int RAW     = $clog2(NPIX);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [AW-1:0] X_AW     = AW'(X_SCREEN_PIXELS);
  localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
  localparam logic [8:0]    X_LIM    = 9'(X_SCREEN_PIXELS);
  localparam logic [7:0]    Y_LIM    = 8'(Y_SCREEN_PIXELS);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic          pix_en;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          vis_c, hs_c, vs_c;
  logic [AW-1:0] v_half, h_half, rd_addr_c, rd_addr_q;
  // {visible, hs, vs} delayed to line up with the registered RAM read
  logic [1:0][2:0] sync_pipe;
  logic [2:0]    rgb_q;
  logic [0:0]    state;
  logic [AW-1:0] clr_addr;
  logic          we;
  logic [AW-1:0] wa;
  logic [2:0]    wd;
  logic [2:0]    fb [NPIX];

  assign vis_c = (h < H_VIS) && (v < V_VIS);
  assign hs_c  = !((h >= HS_BEG) && (h < HS_END));
  assign vs_c  = !((v >= VS_BEG) && (v < VS_END));

  assign v_half = AW'(v >> 1);
  assign h_half = AW'(h >> 1);

  generate
    if (X_SCREEN_PIXELS == 320) begin : g_shift
      assign rd_addr_c = (v_half << 8) + (v_half << 6) + h_half;
    end else begin : g_mul
      assign rd_addr_c = v_half * X_AW + h_half;
    end
  endgenerate

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      pix_en    <= 1'b0;
      h         <= '0;
      v         <= '0;
      rd_addr_q <= '0;
      sync_pipe <= {2{3'b011}};
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
      // park the address in blanking so it never leaves the RAM
      rd_addr_q    <= vis_c ? rd_addr_c : '0;
      sync_pipe[0] <= {vis_c, hs_c, vs_c};
      sync_pipe[1] <= sync_pipe[0];
    end
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state    <= S_IDLE;
      clr_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (iClear) begin
          state    <= S_CLEAR;
          clr_addr <= '0;
        end
        default: begin
          if (clr_addr == PIX_LAST) state <= S_IDLE;
          else                      clr_addr <= clr_addr + 1'b1;
        end
      endcase
    end
  end

  // Sweep owns the write port; a plot in the cycle iClear is seen is dropped.
  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (state == S_CLEAR) begin
      we = 1'b1;
      wa = clr_addr;
      wd = BACKGROUND;
    end else if (iPlot && !iClear && (iX < X_LIM) && (iY < Y_LIM)) begin
      we = 1'b1;
      wa = AW'(iY) * X_AW + AW'(iX);
      wd = iColour;
    end
  end

  always_ff @(posedge iClock) begin
    if (we) fb[wa[RAW-1:0]] <= wd;
    rgb_q <= fb[rd_addr_q[RAW-1:0]];
  end

  assign oBusy        = (state == S_CLEAR);
  assign oVGA_BLANK_N = sync_pipe[1][2];
  assign oVGA_HS      = sync_pipe[1][1];
  assign oVGA_VS      = sync_pipe[1][0];
  assign oVGA_R       = {8{sync_pipe[1][2] & rgb_q[2]}};
  assign oVGA_G       = {8{sync_pipe[1][2] & rgb_q[1]}};
  assign oVGA_B       = {8{sync_pipe[1][2] & rgb_q[0]}};
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_CLK     = pix_en;
  assign oFrameStart  = pix_en && (h == '0) && (v == '0);
endmodule

// File: tb/tb_vga_plot_scanout.sv
// Scaled-down raster checked cycle by cycle against an arithmetic model of
// the frame and a behavioural framebuffer array.
module tb_vga_plot_scanout;
  localparam int X = 16, Y = 12;
  localparam int HV = 32, HF = 4, HS = 8, HB = 4;
  localparam int VV = 24, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = 2 * HT * VT;
  localparam int NPIX = X * Y;
  localparam logic [2:0] BG = 3'b011;

  logic       clk = 0, rst_n = 0;
  logic [8:0] iX = 0;
  logic [7:0] iY = 0;
  logic [2:0] iColour = 0;
  logic       iPlot = 0, iClear = 0;
  logic       oBusy, oHS, oVS, oBLANK_N, oSYNC_N, oVCLK, oFS;
  logic [7:0] oR, oG, oB;

  int checks = 0, errors = 0, cyc = 0;
  logic [2:0] fb [NPIX];
  bit         known [NPIX];

  vga_plot_scanout #(
    .X_SCREEN_PIXELS(X), .Y_SCREEN_PIXELS(Y), .BACKGROUND(BG),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .iClock(clk), .iResetn(rst_n), .iX(iX), .iY(iY), .iColour(iColour),
    .iPlot(iPlot), .iClear(iClear), .oBusy(oBusy),
    .oVGA_R(oR), .oVGA_G(oG), .oVGA_B(oB), .oVGA_HS(oHS), .oVGA_VS(oVS),
    .oVGA_BLANK_N(oBLANK_N), .oVGA_SYNC_N(oSYNC_N), .oVGA_CLK(oVCLK),
    .oFrameStart(oFS)
  );

  always #10 clk = ~clk;

  // cycles since reset release; index c = state after c rising edges
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // expected {fs, pclk, hs, vs, blank, R, G, B} for cycle c
  function automatic logic [28:0] exp_out(input int c, output logic [28:0] mask);
    logic fs, pclk, hs, vs, vis;
    logic [2:0] col;
    int p, hh, vv, a;
    fs   = (c % 2 == 1) && ((c / 2) % (HT * VT) == 0);
    pclk = (c % 2 == 1);
    mask = '1;
    col  = 3'b000;
    if (c < 2) begin
      vis = 0; hs = 1; vs = 1;
    end else begin
      p  = (c - 2) / 2;
      hh = p % HT;
      vv = (p / HT) % VT;
      vis = (hh < HV) && (vv < VV);
      hs  = !(hh >= HV + HF && hh < HV + HF + HS);
      vs  = !(vv >= VV + VF && vv < VV + VF + VS);
      if (vis) begin
        a = (vv / 2) * X + hh / 2;
        if (known[a]) col = fb[a];
        else          mask[23:0] = '0;
      end
    end
    return {fs, pclk, hs, vs, vis, {8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
  endfunction

  task automatic check_frames(input int ncyc, input string tag);
    logic [28:0] e, m, a;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      e = exp_out(cyc, m);
      a = {oFS, oVCLK, oHS, oVS, oBLANK_N, oR, oG, oB};
      checks++;
      if (((a ^ e) & m) !== 29'd0) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h expected=%h mask=%h", tag, cyc, a, e, m);
      end
    end
  endtask

  task automatic plot(input int x, input int y, input logic [2:0] col, input bit lands);
    @(negedge clk);
    iX = 9'(x); iY = 8'(y); iColour = col; iPlot = 1;
    @(negedge clk);
    iPlot = 0;
    if (lands) begin fb[y * X + x] = col; known[y * X + x] = 1; end
  endtask

  task automatic set_all_bg(input int upto);
    for (int a = 0; a < upto; a++) begin fb[a] = BG; known[a] = 1; end
  endtask

  // Start a sweep; optionally plot (0,0) at busy sample plot_at, or reset at reset_at.
  task automatic do_clear(input int plot_at, input int reset_at, input string tag);
    int n;
    @(negedge clk); iClear = 1;
    @(posedge clk); #1; iClear = 0;
    n = 0;
    while (oBusy === 1'b1 && n < NPIX + 10) begin
      n++;
      if (n == plot_at) begin iX = 0; iY = 0; iColour = 3'b100; iPlot = 1; end
      else iPlot = 0;
      if (n == reset_at) begin
        rst_n = 0; #1;
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("FAIL %s busy_in_reset got=%b expected=0", tag, oBusy); end
        checks++;
        if ({oHS, oVS, oBLANK_N, oR, oG, oB} !== {3'b110, 24'd0}) begin
          errors++; $display("FAIL %s outputs_in_reset got=%b%b%b %h%h%h", tag, oHS, oVS, oBLANK_N, oR, oG, oB);
        end
        set_all_bg(n - 1);  // edges 1..n-1 of the sweep wrote addresses 0..n-2
        repeat (3) @(negedge clk);
        rst_n = 1;
        return;
      end
      @(posedge clk); #1;
    end
    iPlot = 0;
    checks++;
    if (n != NPIX) begin errors++; $display("FAIL %s busy_len got=%0d expected=%0d", tag, n, NPIX); end
    set_all_bg(NPIX);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", oBusy); end
    checks++;
    if ({oHS, oVS, oBLANK_N} !== 3'b110) begin errors++; $display("FAIL reset_sync got=%b expected=110", {oHS, oVS, oBLANK_N}); end
    checks++;
    if ({oR, oG, oB} !== 24'd0) begin errors++; $display("FAIL reset_rgb got=%h expected=0", {oR, oG, oB}); end
    checks++;
    if ({oFS, oVCLK, oSYNC_N} !== 3'b000) begin errors++; $display("FAIL reset_misc got=%b expected=000", {oFS, oVCLK, oSYNC_N}); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_timing;
    check_frames(2 * FR, "timing");
  endtask

  task automatic test_clear_sweep;
    do_clear(50, -1, "clear");
    check_frames(FR, "clear_frame");
  endtask

  task automatic test_corners;
    plot(0, 0, 3'b110, 1);
    plot(X - 1, Y - 1, 3'b001, 1);
    check_frames(FR, "corners");
  endtask

  task automatic test_out_of_range;
    plot(X, 10, 3'b111, 0);
    plot(5, Y, 3'b111, 0);
    check_frames(FR, "out_of_range");
  endtask

  task automatic test_back_to_back;
    int x, y;
    logic [2:0] c;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      x = $urandom_range(0, X + 3);
      y = $urandom_range(0, Y + 2);
      c = 3'($urandom);
      iX = 9'(x); iY = 8'(y); iColour = c; iPlot = 1;
      if (x < X && y < Y) begin fb[y * X + x] = c; known[y * X + x] = 1; end
    end
    @(negedge clk); iPlot = 0;
    check_frames(FR, "random_plots");
  endtask

  task automatic test_clear_plot_same;
    plot(10, 10, 3'b101, 1);
    @(negedge clk);
    iClear = 1; iPlot = 1; iX = 10; iY = 10; iColour = 3'b110;
    @(negedge clk);
    iClear = 0; iPlot = 0;
    checks++;
    if (oBusy !== 1'b1) begin errors++; $display("FAIL clr_plot_busy got=%b expected=1", oBusy); end
    for (int i = 0; i < NPIX + 10 && oBusy === 1'b1; i++) @(negedge clk);
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("FAIL clr_plot_done got=%b expected=0", oBusy); end
    set_all_bg(NPIX);
    check_frames(FR, "clr_plot_frame");
  endtask

  task automatic test_reset_mid_clear;
    logic [2:0] c;
    for (int a = 0; a < NPIX; a++) begin
      @(negedge clk);
      c = 3'($urandom);
      iX = 9'(a % X); iY = 8'(a / X); iColour = c; iPlot = 1;
      fb[a] = c; known[a] = 1;
    end
    @(negedge clk); iPlot = 0;
    do_clear(-1, 75, "mid_clear");
    check_frames(FR, "mid_clear_frame");
  endtask

  initial begin
    for (int a = 0; a < NPIX; a++) known[a] = 0;
    test_reset;
    test_timing;
    test_clear_sweep;
    test_corners;
    test_out_of_range;
    test_back_to_back;
    test_clear_plot_same;
    test_reset_mid_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
